filter_channel_scheduler: RTL and testbench
===========================================

// Module: filter_channel_scheduler
// PURPOSE
//   Time-multiplexes one 3-tap (1,2,1)/4 smoothing datapath across NCH independent sample
//   channels. Round-robin arbitration picks one requester; its private 2-deep delay context
//   is swapped in, one output is computed and the updated context is written back.
//   Sits between per-channel sample sources and a single downstream consumer.
// PARAMETERS
//   NCH  4  number of requesting channels (>=2)
//   W    8  sample width, input and output
// PORTS
//   CLK        in   1           clock; all state updates on posedge
//   RST        in   1           synchronous, active-high reset
//   in_valid   in   NCH         per-channel sample request
//   in_data    in   NCH*W       channel c sample at [c*W +: W]
//   in_ready   out  NCH         one-hot accept strobe (at most one bit set)
//   clr_en     in   1           clear one channel's delay context
//   clr_ch     in   $clog2(NCH) channel to clear
//   out_valid  out  1           result available
//   out_data   out  W           filtered sample
//   out_ch     out  $clog2(NCH) channel that produced out_data
//   out_ready  in   1           consumer accepts result
// BEHAVIOUR
//   - Reset: state IDLE; in_ready=0, out_valid=0, out_data=0, out_ch=0, rr_ptr=0,
//     every context (d1,d2)=0. RST mid-operation drops any in-flight sample/result.
//   - FSM IDLE -> COMPUTE -> OUTPUT -> IDLE.
//   - IDLE: in_ready is combinational: bit g set where g = first c with in_valid[c],
//     searching rr_ptr, rr_ptr+1, ... wrapping mod NCH. Transfer = in_valid&in_ready;
//     latch x=in_data[g], ch=g; go COMPUTE. No valid -> stay IDLE, in_ready=0.
//   - COMPUTE (1 cycle): sum = d2 + (d1<<1) + x in W+2 bits (no wrap);
//     out_data <= sum>>2 (exact, max 255 for W=8); out_ch <= ch; out_valid <= 1;
//     ctx[ch] <= {d1=x, d2=old d1}; go OUTPUT. in_ready=0.
//   - OUTPUT: out_valid/out_data/out_ch held stable until out_ready=1; that cycle
//     out_valid <= 0, rr_ptr <= ch+1 mod NCH, go IDLE. in_ready=0 throughout.
//   - Latency: transfer in cycle T -> out_valid high from T+2. Peak rate: one
//     sample per 3 cycles with out_ready tied high.
//   - in_valid deasserted before grant: no transfer, no state change.
//   - Clear: clr_en zeroes ctx[clr_ch] at next edge. If it coincides with the COMPUTE
//     write-back to the same channel, clear wins (ctx becomes 0,0); the in-flight
//     result is unaffected. Clear may occur in any state; no effect on FSM.
//   - clr_ch >= NCH ignored.
// STRUCTURE
//   Shared package filter_pkg: W default, tap constants (1,2,1), shift=2, state enum
//     {IDLE,COMPUTE,OUTPUT}, ctx_t struct {d1,d2}.
//   Sub-module fir3_kernel: pure combinational (x,d1,d2) -> (y, new d1, new d2);
//     reused so stateful filter and scheduler stay bit-exact. Arbiter, FSM and
//     NCH-entry context register file live in this module.
// TESTING
//   1 Ch0 only, samples 4,8,12 -> out_data 1,4,8, out_ch=0, each 2 cycles after accept.
//   2 Ch1 samples 255,255,255 -> 63,191,255 (no wrap in intermediate sum).
//   3 All in_valid held high, out_ready=1 -> grant order 0,1,2,3,0,1; one in_ready bit max.
//   4 Interleave ch0 {4,8} and ch2 {100,200} -> ch0 4→1,8→4; ch2 100→25,200→100 (isolation).
//   5 out_ready low 5 cycles in OUTPUT -> out_* stable, in_ready=0; releases next cycle.
//   6 clr_en on ch0 same cycle as ch0 COMPUTE, then sample 8 -> output 2 (ctx zeroed);
//     RST during OUTPUT -> out_valid=0 next cycle, all contexts 0.

Source files
------------

// File: rtl/filter_pkg.sv
// Shared definitions for the channel-multiplexed (1,2,1)/4 smoothing filter:
// tap weights, output shift, scheduler states and the per-channel delay context.
package filter_pkg;

    localparam int W_DEF = 8;

    localparam int TAP0  = 1;
    localparam int TAP1  = 2;
    localparam int TAP2  = 1;
    localparam int SHIFT = 2;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        OUTPUT
    } state_t;

    typedef struct packed {
        logic [W_DEF-1:0] d1;
        logic [W_DEF-1:0] d2;
    } ctx_t;

endpackage

// File: rtl/fir3_kernel.sv
// Combinational 3-tap (1,2,1)/4 step: one new sample plus a 2-deep delay context
// in, filtered sample plus the shifted context out. Shared by every filter user.
module fir3_kernel
    import filter_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    output logic [W-1:0] y,
    output logic [W-1:0] new_d1,
    output logic [W-1:0] new_d2
);

    localparam logic [W+1:0] K0 = (W+2)'(TAP0);
    localparam logic [W+1:0] K1 = (W+2)'(TAP1);
    localparam logic [W+1:0] K2 = (W+2)'(TAP2);

    // Two guard bits hold the full weighted sum, so the shift below is exact.
    function automatic logic [W-1:0] scale_out(input logic [W+1:0] s);
        return W'(s >> SHIFT);
    endfunction

    logic [W+1:0] sum;

    always_comb begin
        sum    = K2 * {2'b00, d2} + K1 * {2'b00, d1} + K0 * {2'b00, x};
        y      = scale_out(sum);
        new_d1 = x;
        new_d2 = d1;
    end

endmodule

// File: rtl/filter_channel_scheduler.sv
// Round-robin scheduler sharing one fir3_kernel across NCH channels, each with its
// own delay context that is swapped in for one compute cycle and written back.
module filter_channel_scheduler
    import filter_pkg::*;
#(
    parameter int NCH = 4,
    parameter int W   = W_DEF
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NCH-1:0]         in_valid,
    input  logic [NCH*W-1:0]       in_data,
    output logic [NCH-1:0]         in_ready,
    input  logic                   clr_en,
    input  logic [$clog2(NCH)-1:0] clr_ch,
    output logic                   out_valid,
    output logic [W-1:0]           out_data,
    output logic [$clog2(NCH)-1:0] out_ch,
    input  logic                   out_ready
);

    localparam int CW = $clog2(NCH);

    state_t        state;
    logic [CW-1:0] rr_ptr;
    logic [CW-1:0] grant_idx;
    logic          grant_found;

    logic [W-1:0]  x_p0;
    logic [CW-1:0] ch_p0;

    logic [W-1:0]  ctx_d1 [NCH];
    logic [W-1:0]  ctx_d2 [NCH];

    logic [W-1:0]  k_y;
    logic [W-1:0]  k_d1;
    logic [W-1:0]  k_d2;

    // Search starts at rr_ptr and wraps, so the last served channel goes to the back.
    always_comb begin
        int c;
        c           = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NCH; i++) begin
            c = int'(rr_ptr) + i;
            if (c >= NCH) c = c - NCH;
            if (!grant_found && in_valid[c]) begin
                grant_found = 1'b1;
                grant_idx   = CW'(c);
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (state == IDLE && grant_found) in_ready[grant_idx] = 1'b1;
    end

    fir3_kernel #(
        .W(W)
    ) u_kernel (
        .x      (x_p0),
        .d1     (ctx_d1[ch_p0]),
        .d2     (ctx_d2[ch_p0]),
        .y      (k_y),
        .new_d1 (k_d1),
        .new_d2 (k_d2)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            x_p0      <= '0;
            ch_p0     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            for (int c = 0; c < NCH; c++) begin
                ctx_d1[c] <= '0;
                ctx_d2[c] <= '0;
            end
        end else begin
            case (state)
                // stage p0: capture the granted sample and its channel
                IDLE: begin
                    if (grant_found) begin
                        x_p0  <= in_data[int'(grant_idx)*W +: W];
                        ch_p0 <= grant_idx;
                        state <= COMPUTE;
                    end
                end
                // stage p1: filter against the channel context and write it back
                COMPUTE: begin
                    out_data       <= k_y;
                    out_ch         <= ch_p0;
                    out_valid      <= 1'b1;
                    ctx_d1[ch_p0]  <= k_d1;
                    ctx_d2[ch_p0]  <= k_d2;
                    state          <= OUTPUT;
                end
                // stage p2: hold the result until the consumer takes it
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        rr_ptr    <= (int'(ch_p0) == NCH - 1) ? '0 : ch_p0 + CW'(1);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Placed after the write-back so a same-channel clear takes priority.
            if (clr_en && int'(clr_ch) < NCH) begin
                ctx_d1[clr_ch] <= '0;
                ctx_d2[clr_ch] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_filter_channel_scheduler.sv
// Bench for filter_channel_scheduler: directed scenarios plus randomized traffic
// checked against a per-channel sample-history model of the (1,2,1)/4 filter.
module tb_filter_channel_scheduler;

    localparam int NCH = 4;
    localparam int W   = 8;
    localparam int CW  = $clog2(NCH);

    logic             CLK = 1'b0;
    logic             RST;
    logic [NCH-1:0]   in_valid;
    logic [NCH*W-1:0] in_data;
    logic [NCH-1:0]   in_ready;
    logic             clr_en;
    logic [CW-1:0]    clr_ch;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [CW-1:0]    out_ch;
    logic             out_ready;

    filter_channel_scheduler #(
        .NCH(NCH),
        .W  (W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .clr_en    (clr_en),
        .clr_ch    (clr_ch),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Model: last two samples seen per channel and the next round-robin start.
    int m_prev1 [NCH];
    int m_prev2 [NCH];
    int m_rr;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_prev1[c] = 0;
            m_prev2[c] = 0;
        end
        m_rr = 0;
    endtask

    task automatic model_clear(input int c);
        m_prev1[c] = 0;
        m_prev2[c] = 0;
    endtask

    function automatic logic [NCH*W-1:0] pack(input int c, input int v);
        logic [NCH*W-1:0] r;
        r = '0;
        r[c*W +: W] = W'(v);
        return r;
    endfunction

    function automatic logic [NCH*W-1:0] rand_data();
        logic [NCH*W-1:0] r;
        r = '0;
        for (int c = 0; c < NCH; c++) r[c*W +: W] = W'($urandom);
        return r;
    endfunction

    task automatic reset_dut();
        @(negedge CLK);
        RST = 1'b1; in_valid = '0; clr_en = 1'b0; out_ready = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_ch", int'(out_ch), 0);
        check("rst_in_ready", int'(in_ready), 0);
        RST = 1'b0;
        model_reset();
    endtask

    task automatic idle_cycle(input bit do_clr, input int c);
        @(negedge CLK);
        in_valid = '0; in_data = rand_data(); out_ready = 1'b0;
        clr_en = do_clr; clr_ch = CW'(c);
        #1;
        check("idle_in_ready", int'(in_ready), 0);
        check("idle_out_valid", int'(out_valid), 0);
        if (do_clr) model_clear(c);
    endtask

    // One full request/compute/output round; clr_phase 1 clears during the accept
    // cycle, 2 during the compute cycle. abort resets the DUT while the result waits.
    task automatic txn(input logic [NCH-1:0] mask, input logic [NCH*W-1:0] data,
                       input int stall, input int clr_phase, input int clr_c,
                       input bit abort);
        int g, x, y;
        g = -1;
        for (int i = 0; i < NCH; i++) begin
            int c;
            c = (m_rr + i) % NCH;
            if (g < 0 && mask[c]) g = c;
        end
        x = int'(data[g*W +: W]);

        @(negedge CLK);
        out_ready = 1'b0; in_valid = mask; in_data = data;
        clr_en = (clr_phase == 1); clr_ch = CW'(clr_c);
        #1;
        check("idle_out_valid", int'(out_valid), 0);
        check("grant", int'(in_ready), 1 << g);
        if (clr_phase == 1) model_clear(clr_c);

        y = (m_prev2[g] + 2 * m_prev1[g] + x) / 4;
        m_prev2[g] = m_prev1[g];
        m_prev1[g] = x;

        @(negedge CLK);
        clr_en = (clr_phase == 2);
        #1;
        check("compute_in_ready", int'(in_ready), 0);
        check("compute_out_valid", int'(out_valid), 0);
        if (clr_phase == 2) model_clear(clr_c);

        @(negedge CLK);
        clr_en = 1'b0;
        #1;
        check("out_valid", int'(out_valid), 1);
        check("out_data", int'(out_data), y);
        check("out_ch", int'(out_ch), g);
        check("output_in_ready", int'(in_ready), 0);

        for (int k = 0; k < stall; k++) begin
            @(negedge CLK);
            #1;
            check("stall_out_valid", int'(out_valid), 1);
            check("stall_out_data", int'(out_data), y);
            check("stall_out_ch", int'(out_ch), g);
            check("stall_in_ready", int'(in_ready), 0);
        end

        if (abort) begin
            RST = 1'b1; in_valid = '0;
            @(negedge CLK);
            #1;
            check("abort_out_valid", int'(out_valid), 0);
            check("abort_out_data", int'(out_data), 0);
            check("abort_out_ch", int'(out_ch), 0);
            check("abort_in_ready", int'(in_ready), 0);
            RST = 1'b0;
            model_reset();
        end else begin
            out_ready = 1'b1;
            m_rr = (g + 1) % NCH;
        end
    endtask

    initial begin
        RST = 1'b1; in_valid = '0; in_data = '0;
        clr_en = 1'b0; clr_ch = '0; out_ready = 1'b0;
        model_reset();
        reset_dut();

        // ch0 ramp, then ch1 saturated input
        txn(4'b0001, pack(0, 4),   0, 0, 0, 0);
        txn(4'b0001, pack(0, 8),   0, 0, 0, 0);
        txn(4'b0001, pack(0, 12),  0, 0, 0, 0);
        txn(4'b0010, pack(1, 255), 0, 0, 0, 0);
        txn(4'b0010, pack(1, 255), 0, 0, 0, 0);
        txn(4'b0010, pack(1, 255), 0, 0, 0, 0);

        // clear coinciding with ch0 write-back, then a fresh-context sample
        txn(4'b0001, pack(0, 16), 0, 2, 0, 0);
        txn(4'b0001, pack(0, 8),  0, 0, 0, 0);

        // consumer stalls five cycles, then reset while the result is held
        txn(4'b0010, pack(1, 7), 5, 0, 0, 1);

        // all channels requesting continuously
        for (int k = 0; k < 6; k++) txn(4'b1111, rand_data(), 0, 0, 0, 0);

        // isolation between two interleaved channels
        idle_cycle(1'b1, 0);
        idle_cycle(1'b1, 2);
        txn(4'b0001, pack(0, 4),   0, 0, 0, 0);
        txn(4'b0100, pack(2, 100), 0, 0, 0, 0);
        txn(4'b0001, pack(0, 8),   0, 0, 0, 0);
        txn(4'b0100, pack(2, 200), 0, 0, 0, 0);

        for (int k = 0; k < 3; k++) idle_cycle(1'b0, 0);

        for (int k = 0; k < 80; k++) begin
            logic [NCH-1:0] mask;
            int clr_phase;
            mask      = NCH'($urandom_range(1, (1 << NCH) - 1));
            clr_phase = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            txn(mask, rand_data(), int'($urandom_range(0, 2)), clr_phase,
                int'($urandom_range(0, NCH - 1)), ($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 4) == 0)
                idle_cycle($urandom_range(0, 1) == 1, int'($urandom_range(0, NCH - 1)));
        end

        idle_cycle(1'b0, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
